hamming_dec_arb: RTL and testbench
==================================

HAMMING_DEC_ARB -- requirements
Module: hamming_dec_arb

Interface
REQ-001 SHALL have parameter: CNT_W, 16, width of the corrected-codeword counter (min 4).
REQ-002 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: s0_valid in 1, s0_ready out 1, s0_data in 15  requester 0 codeword handshake.
REQ-005 SHALL have ports: s1_valid in 1, s1_ready out 1, s1_data in 15  requester 1 codeword handshake.
REQ-006 SHALL have ports: m_valid out 1, m_ready in 1  output handshake.
REQ-007 SHALL have port: m_data  out  11  corrected data bits.
REQ-008 SHALL have port: m_src  out  1  requester index of m_data.
REQ-009 SHALL have port: m_syn  out  4  syndrome of the codeword; 0 means no error.
REQ-010 SHALL have port: corr_cnt  out  CNT_W  count of codewords with nonzero syndrome (HAMMING_ERR_CNT_EN only).

Function
REQ-011 SHALL share one Hamming(15,11) correction datapath between two requesters; the transfer rule is valid&ready high at a rising clk edge.
REQ-012 Syndrome bit k SHALL be XOR of codeword bits whose 1-based position has bit k set; nonzero syndrome S SHALL invert codeword bit S-1 before extraction.
REQ-013 Data extraction SHALL map codeword bits 2,4,5,6,8..14 to m_data[0..10] in ascending order; the parity positions (bits 0,1,3,7) SHALL be dropped.
REQ-014 SHALL hold a single-entry output register; FSM states EMPTY (m_valid=0) and FULL (m_valid=1).
REQ-015 EMPTY->FULL on any accepted input; FULL->EMPTY on m_ready with no input accepted; FULL->FULL on m_ready with an input accepted (back-to-back, no bubble); FULL with m_ready=0 SHALL hold m_data/m_src/m_syn stable.
REQ-016 Input acceptance permitted (accept_ok) when state is EMPTY or m_ready=1; latency from input handshake to m_valid SHALL be exactly 1 cycle.
REQ-017 Arbitration SHALL be round-robin with a 1-bit priority pointer; only the granted requester sees ready=1, the other ready=0.
REQ-018 Both valid: grant the pointer's requester; one valid: grant it regardless of pointer; neither: no grant, pointer unchanged.
REQ-019 After each accepted transfer the pointer SHALL point to the requester not granted.
REQ-020 s0_ready/s1_ready SHALL depend combinationally on valids, pointer, state and m_ready only, never on data.
REQ-021 A requester dropping valid without handshake SHALL cause no state change.

Reset
REQ-022 rst_n low SHALL asynchronously force: state EMPTY, m_valid=0, m_data=0, m_src=0, m_syn=0, pointer=0 (requester 0 priority), corr_cnt=0.
REQ-023 Reset asserted while FULL SHALL discard the buffered word with no output handshake; first cycle after release behaves as from EMPTY.
REQ-024 s0_ready and s1_ready SHALL be 0 while rst_n is low.

Configuration
REQ-025 Macro HAMMING_ERR_CNT_EN defined: corr_cnt SHALL increment by 1 on each accepted input whose syndrome is nonzero, saturating at all-ones (no wrap).
REQ-026 Macro HAMMING_ERR_CNT_EN undefined: corr_cnt port and counter logic SHALL be absent; all other behaviour unchanged.

Verification
REQ-027 Reset, then s0_data=15'h0000 valid, m_ready=1 -> next cycle m_valid=1, m_data=11'h000, m_syn=0, m_src=0.
REQ-028 s1 sends an all-ones codeword (15'h7FFF) with bit 4 flipped (15'h7FEF) -> m_syn=5, m_data=11'h7FF, m_src=1, corr_cnt=1.
REQ-029 s0 and s1 valid for 4 cycles, m_ready=1 -> grants 0,1,0,1, m_valid high every cycle, no bubble.
REQ-030 m_ready=0 for 3 cycles while FULL with both valid -> s0_ready=s1_ready=0, m_data stable; m_ready=1 -> stall released in one cycle.
REQ-031 Pulse rst_n low while FULL -> m_valid=0 immediately (async), pointer=0, corr_cnt=0.
REQ-032 With macro defined and CNT_W=4, feed 20 single-error codewords -> corr_cnt saturates at 4'hF.

Source files
------------

// File: rtl/hamming_dec_arb.sv
// Two-requester round-robin front end sharing one Hamming(15,11) single-error corrector,
// with a one-entry output buffer. Optional error counter enabled by HAMMING_ERR_CNT_EN.
module hamming_dec_arb #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s0_valid,
    output logic             s0_ready,
    input  logic [14:0]      s0_data,
    input  logic             s1_valid,
    output logic             s1_ready,
    input  logic [14:0]      s1_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [10:0]      m_data,
    output logic             m_src,
    output logic [3:0]       m_syn
`ifdef HAMMING_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0] corr_cnt
`endif
);

    localparam int unsigned CW_W  = 15;
    localparam int unsigned D_W   = 11;
    localparam int unsigned SYN_W = 4;

    // 1-based codeword positions that carry data bits, in m_data order
    localparam logic [SYN_W-1:0] DPOS [D_W] = '{
        4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
    };

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_ptr;
    logic [D_W-1:0]     r_data;
    logic               r_src;
    logic [SYN_W-1:0]   r_syn;

    logic               w_accept_ok;
    logic               w_gnt;
    logic               w_accept;
    logic [CW_W-1:0]    w_code;
    logic [SYN_W-1:0]   w_syn;
    logic [D_W-1:0]     w_raw;
    logic [D_W-1:0]     w_data;

    // Arbitration: pointer only matters when both requesters are valid
    always_comb begin
        w_gnt = s1_valid;
        if (s0_valid && s1_valid) begin
            w_gnt = r_ptr;
        end
    end

    assign s0_ready = rst_n & w_accept_ok & s0_valid & ~w_gnt;
    assign s1_ready = rst_n & w_accept_ok & s1_valid &  w_gnt;
    assign w_accept = s0_ready | s1_ready;
    assign w_code   = w_gnt ? s1_data : s0_data;

    // Syndrome is the XOR of the 1-based positions of all set bits
    always_comb begin
        w_syn = '0;
        for (int i = 0; i < int'(CW_W); i++) begin
            if (w_code[i]) begin
                w_syn = w_syn ^ SYN_W'(i + 1);
            end
        end
    end

    assign w_raw = {w_code[14:8], w_code[6:4], w_code[2]};

    // A syndrome pointing at a parity position leaves the data untouched
    always_comb begin
        w_data = w_raw;
        for (int i = 0; i < int'(D_W); i++) begin
            w_data[i] = w_raw[i] ^ (w_syn == DPOS[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
            ST_FULL:  if (m_ready && !w_accept) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    always_comb begin
        m_valid     = 1'b0;
        w_accept_ok = 1'b1;
        case (r_state)
            ST_EMPTY: begin
                m_valid     = 1'b0;
                w_accept_ok = 1'b1;
            end
            ST_FULL: begin
                m_valid     = 1'b1;
                w_accept_ok = m_ready;
            end
            default: begin
                m_valid     = 1'b0;
                w_accept_ok = 1'b1;
            end
        endcase
    end

    // Output buffer and pointer only move on an accepted input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr  <= 1'b0;
            r_data <= '0;
            r_src  <= 1'b0;
            r_syn  <= '0;
        end else if (w_accept) begin
            r_ptr  <= ~w_gnt;
            r_data <= w_data;
            r_src  <= w_gnt;
            r_syn  <= w_syn;
        end
    end

    assign m_data = r_data;
    assign m_src  = r_src;
    assign m_syn  = r_syn;

`ifdef HAMMING_ERR_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    // Saturating count of corrected codewords
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_accept && (w_syn != '0) && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign corr_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_hamming_dec_arb.sv
// Scoreboard bench for hamming_dec_arb: directed codewords with hand-computed results.
// Counter checks are compiled in only when HAMMING_ERR_CNT_EN is defined.
module tb_hamming_dec_arb;

    localparam int unsigned CNT_W = 4;

    typedef struct packed {
        logic        src;
        logic [10:0] data;
        logic [3:0]  syn;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        s0_valid;
    logic        s0_ready;
    logic [14:0] s0_data;
    logic        s1_valid;
    logic        s1_ready;
    logic [14:0] s1_data;
    logic        m_valid;
    logic        m_ready;
    logic [10:0] m_data;
    logic        m_src;
    logic [3:0]  m_syn;
`ifdef HAMMING_ERR_CNT_EN
    logic [CNT_W-1:0] corr_cnt;
`endif

    hamming_dec_arb #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s0_valid (s0_valid),
        .s0_ready (s0_ready),
        .s0_data  (s0_data),
        .s1_valid (s1_valid),
        .s1_ready (s1_ready),
        .s1_data  (s1_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_src    (m_src),
        .m_syn    (m_syn)
`ifdef HAMMING_ERR_CNT_EN
        ,
        .corr_cnt (corr_cnt)
`endif
    );

    int          checks   = 0;
    int          failures = 0;
    exp_t        q[$];
    exp_t        mon_e;
    logic [10:0] e0_data, e1_data;
    logic [3:0]  e0_syn,  e1_syn;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: retire output handshakes against the queue, then log new input handshakes
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid && m_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got data %h, expected no output", m_data);
                end else begin
                    mon_e = q.pop_front();
                    chk("out_data", 32'(m_data), 32'(mon_e.data));
                    chk("out_syn",  32'(m_syn),  32'(mon_e.syn));
                    chk("out_src",  32'(m_src),  32'(mon_e.src));
                end
            end
            if (s0_valid && s0_ready) q.push_back('{src: 1'b0, data: e0_data, syn: e0_syn});
            if (s1_valid && s1_ready) q.push_back('{src: 1'b1, data: e1_data, syn: e1_syn});
        end
    end

    task automatic send(input logic src, input logic [14:0] code,
                        input logic [10:0] ed, input logic [3:0] es);
        bit got = 1'b0;
        if (src) begin
            s1_data = code; e1_data = ed; e1_syn = es; s1_valid = 1'b1;
        end else begin
            s0_data = code; e0_data = ed; e0_syn = es; s0_valid = 1'b1;
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (src ? s1_ready : s0_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got no ready, expected ready for src %0d", src);
        end
        @(posedge clk);
        #1;
        if (src) s1_valid = 1'b0; else s0_valid = 1'b0;
        chk("latency_valid", 32'(m_valid), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        s0_valid = 1'b1;
        s1_valid = 1'b1;
        s0_data  = '0;
        s1_data  = '0;
        m_ready  = 1'b1;
        e0_data  = '0; e0_syn = '0;
        e1_data  = '0; e1_syn = '0;

        // Reset state, readies held low even with valids up
        repeat (2) @(negedge clk);
        chk("rst_s0_ready", 32'(s0_ready), 32'd0);
        chk("rst_s1_ready", 32'(s1_ready), 32'd0);
        chk("rst_m_valid",  32'(m_valid),  32'd0);
        chk("rst_m_data",   32'(m_data),   32'd0);
        chk("rst_m_syn",    32'(m_syn),    32'd0);
        chk("rst_m_src",    32'(m_src),    32'd0);
`ifdef HAMMING_ERR_CNT_EN
        chk("rst_corr_cnt", 32'(corr_cnt), 32'd0);
`endif
        @(posedge clk); #1;
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        rst_n    = 1'b1;

        // Directed codewords
        send(1'b0, 15'h0000, 11'h000, 4'h0);
        send(1'b1, 15'h7FEF, 11'h7FF, 4'h5);
`ifdef HAMMING_ERR_CNT_EN
        chk("corr_cnt_first", 32'(corr_cnt), 32'd1);
`endif
        send(1'b0, 15'h7FFF, 11'h7FF, 4'h0);
        send(1'b1, 15'h0001, 11'h000, 4'h1);
        send(1'b0, 15'h4000, 11'h000, 4'hF);
        send(1'b1, 15'h0004, 11'h000, 4'h3);
        send(1'b0, 15'h0007, 11'h001, 4'h0);
        send(1'b1, 15'h0407, 11'h001, 4'hB);
        drain();
`ifdef HAMMING_ERR_CNT_EN
        chk("corr_cnt_mix", 32'(corr_cnt), 32'd5);
`endif

        // Back-to-back from a fresh reset: grants 0,1,0,1 with no bubble
        @(posedge clk); #1;
        rst_n = 1'b0;
        q.delete();
        #2;
        rst_n    = 1'b1;
        s0_data  = 15'h0000; e0_data = 11'h000; e0_syn = 4'h0; s0_valid = 1'b1;
        s1_data  = 15'h7FFF; e1_data = 11'h7FF; e1_syn = 4'h0; s1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("b2b_s0_ready", 32'(s0_ready), 32'(k % 2 == 0));
            chk("b2b_s1_ready", 32'(s1_ready), 32'(k % 2 == 1));
            if (k > 0) chk("b2b_m_valid", 32'(m_valid), 32'd1);
            @(posedge clk); #1;
        end
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        @(negedge clk);
        chk("b2b_tail_valid", 32'(m_valid), 32'd1);
        drain();

        // Stall while FULL with both requesters waiting
        m_ready  = 1'b0;
        s0_data  = 15'h0007; e0_data = 11'h001; e0_syn = 4'h0; s0_valid = 1'b1;
        s1_data  = 15'h0407; e1_data = 11'h001; e1_syn = 4'hB; s1_valid = 1'b1;
        @(negedge clk);
        chk("stall_gnt0", 32'(s0_ready), 32'd1);
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_s0_ready", 32'(s0_ready), 32'd0);
            chk("stall_s1_ready", 32'(s1_ready), 32'd0);
            chk("stall_m_valid",  32'(m_valid),  32'd1);
            chk("stall_m_data",   32'(m_data),   32'h001);
            chk("stall_m_syn",    32'(m_syn),    32'd0);
            chk("stall_m_src",    32'(m_src),    32'd0);
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        @(negedge clk);
        chk("release_s1_ready", 32'(s1_ready), 32'd1);
        @(posedge clk); #1;
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        @(negedge clk);
        chk("release_m_valid", 32'(m_valid), 32'd1);
        chk("release_m_syn",   32'(m_syn),   32'hB);
        drain();

        // Asynchronous reset while FULL
        m_ready = 1'b0;
        send(1'b0, 15'h7FEF, 11'h7FF, 4'h5);
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("arst_m_valid", 32'(m_valid), 32'd0);
        chk("arst_m_data",  32'(m_data),  32'd0);
        chk("arst_m_syn",   32'(m_syn),   32'd0);
`ifdef HAMMING_ERR_CNT_EN
        chk("arst_corr_cnt", 32'(corr_cnt), 32'd0);
`endif
        @(posedge clk); #1;
        rst_n    = 1'b1;
        m_ready  = 1'b1;
        s0_data  = 15'h0000; e0_data = 11'h000; e0_syn = 4'h0; s0_valid = 1'b1;
        s1_data  = 15'h0001; e1_data = 11'h000; e1_syn = 4'h1; s1_valid = 1'b1;
        @(negedge clk);
        chk("arst_ptr_s0", 32'(s0_ready), 32'd1);
        chk("arst_ptr_s1", 32'(s1_ready), 32'd0);
        @(posedge clk); #1;
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        drain();

        // Twenty single-error codewords drive the counter into saturation
        for (int n = 0; n < 20; n++) begin
            send(1'(n % 2), 15'h0001, 11'h000, 4'h1);
`ifdef HAMMING_ERR_CNT_EN
            if (n == 13) chk("corr_cnt_14", 32'(corr_cnt), 32'd14);
`endif
        end
        drain();
`ifdef HAMMING_ERR_CNT_EN
        chk("corr_cnt_sat", 32'(corr_cnt), 32'hF);
`endif

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
